hdmi_packet_sorter: RTL

Receive-side counterpart of the HDMI data-island packet scheduler. It sits after the TERC4 decode, BCH check and packet assembly stage and accepts one assembled packet at a time (header plus four subpackets). It classifies each packet by HB0 and unpacks Audio Sample packets into a stereo sample FIFO. It also latches Audio Clock Regeneration N/CTS and extracts key fields from the AVI and Audio InfoFrames for the rest of the FM radio audio path.

---
 rtl/hdmi_packet_sorter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/hdmi_packet_sorter.sv
// HDMI data-island packet sorter: ACR/AVI/AIF field capture, audio sample unpack into a FWFT FIFO; fields 1 cycle, audio_valid >= 2 cycles after packet_valid.
// audio_ready pops the FIFO; writes to a full FIFO are dropped and set overflow. Define HDMI_PACKET_SORTER_CHECKSUM_EN to reject bad InfoFrames.

module hdmi_packet_sorter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, push, pop;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = (wr_ptr != rd_ptr);
  assign pop    = rd_vld && rd_rdy;
  // A pop in the same cycle frees the slot, so push-while-full is accepted then.
  assign wr_rdy = !full || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

module hdmi_packet_sorter #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clk_pixel,
  input  logic                            reset_n,
  input  logic                            packet_valid,
  input  logic [23:0]                     header,
  input  logic [3:0][55:0]                sub,
  output logic                            audio_valid,
  input  logic                            audio_ready,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic                            audio_block_start,
  output logic                            acr_update,
  output logic [19:0]                     acr_n,
  output logic [19:0]                     acr_cts,
  output logic [6:0]                      avi_vic,
  output logic                            avi_valid,
  output logic [2:0]                      aif_channel_count,
  output logic                            aif_valid,
  output logic                            overflow,
  output logic [7:0]                      unknown_count,
  output logic [7:0]                      checksum_error_count
);
  localparam int W  = AUDIO_BIT_WIDTH;
  localparam int EW = 2*W + 1;

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t             state;
  logic [3:0]         pending, next_pending;
  logic [3:0][EW-1:0] stage_ent;
  logic [1:0]         sel;
  logic [7:0]         hb0, hb1, hb2;
  logic               is_null, is_acr, is_audio, is_avi, is_aif, is_unknown;
  logic               csum_ok, wr_vld, wr_rdy;
  logic [EW-1:0]      head;
  logic               unused_bits;

  assign {hb2, hb1, hb0} = header;
  assign unused_bits     = ^{header, sub};

  assign is_null    = packet_valid && (hb0 == 8'h00);
  assign is_acr     = packet_valid && (hb0 == 8'h01);
  // Layout 1 audio is not supported and falls through to the unknown counter.
  assign is_audio   = packet_valid && (hb0 == 8'h02) && !hb1[4];
  assign is_avi     = packet_valid && (hb0 == 8'h82);
  assign is_aif     = packet_valid && (hb0 == 8'h84);
  assign is_unknown = packet_valid && !(is_null || is_acr || is_audio || is_avi || is_aif);

`ifdef HDMI_PACKET_SORTER_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = hb0 + hb1 + hb2;
    for (int n = 0; n < 4; n++)
      for (int b = 0; b < 7; b++)
        csum = csum + sub[n][8*b +: 8];
  end
  assign csum_ok = (csum == 8'h00);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)
      checksum_error_count <= '0;
    else if ((is_avi || is_aif) && !csum_ok && checksum_error_count != 8'hFF)
      checksum_error_count <= checksum_error_count + 8'd1;
  end
`else
  assign csum_ok              = 1'b1;
  assign checksum_error_count = '0;
`endif

  // Lowest still-pending subpacket is written each UNPACK cycle.
  always_comb begin
    sel = 2'd0;
    for (int n = 3; n >= 0; n--)
      if (pending[n]) sel = 2'(n);
  end
  assign next_pending = pending & ~(4'b0001 << sel);
  assign wr_vld       = (state == UNPACK);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pending   <= '0;
      stage_ent <= '0;
    end else begin
      case (state)
        IDLE: if (is_audio && hb1[3:0] != 4'd0) begin
          state   <= UNPACK;
          pending <= hb1[3:0];
          for (int n = 0; n < 4; n++)
            stage_ent[n] <= {hb2[4+n], sub[n][47 -: W], sub[n][23 -: W]};
        end
        UNPACK: begin
          pending <= next_pending;
          if (next_pending == 4'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hdmi_packet_sorter_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_pixel),
    .reset_n (reset_n),
    .wr_vld  (wr_vld),
    .wr_rdy  (wr_rdy),
    .wr_dat  (stage_ent[sel]),
    .rd_vld  (audio_valid),
    .rd_rdy  (audio_ready),
    .rd_dat  (head)
  );

  assign {audio_block_start, audio_sample_word[1], audio_sample_word[0]} = head;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_update        <= 1'b0;
      acr_n             <= '0;
      acr_cts           <= '0;
      avi_vic           <= '0;
      avi_valid         <= 1'b0;
      aif_channel_count <= '0;
      aif_valid         <= 1'b0;
      overflow          <= 1'b0;
      unknown_count     <= '0;
    end else begin
      acr_update <= is_acr;
      if (is_acr) begin
        acr_cts <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
        acr_n   <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
      end
      if (is_avi && csum_ok) begin
        avi_vic   <= sub[0][38:32];
        avi_valid <= 1'b1;
      end
      if (is_aif && csum_ok) begin
        aif_channel_count <= sub[0][10:8];
        aif_valid         <= 1'b1;
      end
      // Dropped sample pairs and audio packets landing mid-unpack both count as loss.
      if ((wr_vld && !wr_rdy) || (is_audio && state == UNPACK))
        overflow <= 1'b1;
      if (is_unknown && unknown_count != 8'hFF)
        unknown_count <= unknown_count + 8'd1;
    end
  end
endmodule
